// File: rtl/sram_controller.sv
// 32-bit data-memory responder over a 16-bit asynchronous SRAM, accessed as two half-word phases.
// Optional one-word read buffer enabled by defining SRAM_CTRL_READ_BUFFER_EN.
module sram_controller #(
   parameter int ADDR_BASE   = 1024,
   parameter int WAIT_CYCLES = 5,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        writeData,
   output logic [31:0]        readData,
   output logic               ready,
   inout  wire  [15:0]        SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [31:0]        off;
   logic [SRAM_AW-2:0] word_idx;
   logic               req, last, hit, dq_oe;
   logic [15:0]        dq_out;
   logic               unused_off;

   assign off        = address - 32'(ADDR_BASE);
   assign word_idx   = off[SRAM_AW:2];
   assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
   assign req        = rd_en | wr_en;
   assign last       = (cnt == CW'(WAIT_CYCLES - 1));

`ifdef SRAM_CTRL_READ_BUFFER_EN
   logic               buf_vld;
   logic [SRAM_AW-2:0] buf_tag;

   // A hit answers a read-only request from IDLE without touching the SRAM.
   assign hit = (state == IDLE) & rd_en & ~wr_en & buf_vld & (buf_tag == word_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_vld <= 1'b0;
      end else if (state == IDLE && state_nxt == LOW && wr_en) begin
         buf_vld <= 1'b0;
      end else if (state == HIGH && last && !wr_en) begin
         buf_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == HIGH && last && !wr_en) buf_tag <= word_idx;
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)                  cnt <= '0;
         else if (state == LOW || state == HIGH) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req && !hit) state_nxt = LOW;
         LOW:  if (last)        state_nxt = HIGH;
         HIGH: if (last)        state_nxt = DONE;
         DONE:                  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // The strobe rises on the last cycle of each write phase so address and data are held past it.
   always_comb begin
      SRAM_WE_N = 1'b1;
      dq_oe     = 1'b0;
      dq_out    = writeData[15:0];
      case (state)
         LOW: begin
            dq_oe     = wr_en;
            SRAM_WE_N = ~wr_en | last;
         end
         HIGH: begin
            dq_oe     = wr_en;
            SRAM_WE_N = ~wr_en | last;
            dq_out    = writeData[31:16];
         end
         default: ;
      endcase
      ready = ~req | (state == DONE) | hit;
   end

   assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         SRAM_ADDR <= '0;
         readData  <= '0;
      end else begin
         if (state == IDLE && state_nxt == LOW) SRAM_ADDR <= {word_idx, 1'b0};
         if (state == LOW && last)              SRAM_ADDR <= {word_idx, 1'b1};
         if (state == LOW && last && !wr_en)    readData[15:0]  <= SRAM_DQ;
         if (state == HIGH && last && !wr_en)   readData[31:16] <= SRAM_DQ;
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small SRAM model and a completion scoreboard.
// Buffer-hit vectors run only when SRAM_CTRL_READ_BUFFER_EN is defined.
module tb_sram_controller;

   logic        clk, rst, rd_en, wr_en;
   logic [31:0] address, writeData, readData;
   logic        ready, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;
   logic [17:0] SRAM_ADDR;
   wire  [15:0] dq;

   logic [15:0] mem [0:63];
   logic        model_oe;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] lat;
   } exp_t;
   exp_t sbq[$];

   int total, bad, last_cyc, mon_lat, we_lo;
   exp_t mon_e;
   logic [17:0] addr_log [0:63];
   logic        we_log   [0:63];
   logic [15:0] dq_log   [0:63];

   sram_controller dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .writeData(writeData), .readData(readData), .ready(ready),
      .SRAM_DQ(dq), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous SRAM model: drives reads only while the bench expects a read access.
   assign dq = (model_oe && SRAM_WE_N) ? mem[SRAM_ADDR[5:0]] : 16'hzzzz;
   always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] <= dq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_done();
      last_cyc = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         addr_log[c] = SRAM_ADDR;
         we_log[c]   = SRAM_WE_N;
         dq_log[c]   = dq;
         if (ready) begin
            last_cyc = c;
            break;
         end
      end
      if (last_cyc < 0) check("timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic [31:0] exp_lat);
      sbq.push_back('{rdata: exp_rd, lat: exp_lat});
      model_oe  = r & ~w;
      rd_en     = r;
      wr_en     = w;
      address   = a;
      writeData = d;
      wait_done();
   endtask

   // Monitor: every completed request is matched against the oldest scoreboard entry.
   initial begin
      mon_lat = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_lat = 0;
         end else if (rd_en | wr_en) begin
            if (ready) begin
               if (sbq.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  mon_e = sbq.pop_front();
                  check("readData", readData, mon_e.rdata);
                  check("latency", 32'(mon_lat), mon_e.lat);
               end
               mon_lat = 0;
            end else begin
               mon_lat++;
            end
         end
      end
   end

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; model_oe = 1'b0;
      address = 32'd0; writeData = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_readData", readData, 32'd0);
      check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      check("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
      check("rst_dq_released", {31'd0, dq == writeData[15:0]}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;

      // Store 0x12345678 to 1032 -> half-words 4 (0x5678) and 5 (0x1234).
      access(1'b0, 1'b1, 32'd1032, 32'h1234_5678, 32'h0, 32'd11);
      we_lo = 0;
      for (int c = 1; c <= 10; c++) begin
         check("wr_addr", {14'd0, addr_log[c]}, (c <= 5) ? 32'd4 : 32'd5);
         check("wr_dq", {16'd0, dq_log[c]}, (c <= 5) ? 32'h5678 : 32'h1234);
         check("wr_we_n", {31'd0, we_log[c]}, (c == 5 || c == 10) ? 32'd1 : 32'd0);
         if (!we_log[c]) we_lo++;
      end
      check("wr_we_low_cycles", 32'(we_lo), 32'd8);

      // Back-to-back load of the same word.
      access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h1234_5678, 32'd11);
      check("rd_mem_word", {mem[5], mem[4]}, 32'h1234_5678);
      we_lo = 0;
      for (int c = 0; c <= 11; c++) if (!we_log[c]) we_lo++;
      check("rd_no_strobe", 32'(we_lo), 32'd0);
      check("rd_addr_low", {14'd0, addr_log[5]}, 32'd4);
      check("rd_addr_high", {14'd0, addr_log[10]}, 32'd5);

      // Both enables: write wins, readData holds the previous load.
      access(1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D, 32'h1234_5678, 32'd11);
      check("rw_mem_word", {mem[1], mem[0]}, 32'hCAFE_F00D);
      rd_en = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      check("gap_ready", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;

      // Reset in cycle 3 of a write; the held request restarts after release.
      sbq.push_back('{rdata: 32'h0, lat: 32'd11});
      model_oe = 1'b0; wr_en = 1'b1; address = 32'd1036; writeData = 32'h0BAD_BEEF;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      check("mid_rst_ready", {31'd0, ready}, 32'd0);
      check("mid_rst_readData", readData, 32'd0);
      check("mid_rst_dq_released", {31'd0, dq == 16'hBEEF}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      wait_done();
      check("restart_done_cycle", 32'(last_cyc), 32'd11);
      check("restart_mem_word", {mem[7], mem[6]}, 32'h0BAD_BEEF);

      // Address beyond the SRAM size wraps onto word 2.
      access(1'b1, 1'b0, 32'd525320, 32'h0, 32'h1234_5678, 32'd11);
      check("wrap_addr_low", {14'd0, addr_log[1]}, 32'd4);
      check("wrap_addr_high", {14'd0, addr_log[6]}, 32'd5);

`ifdef SRAM_CTRL_READ_BUFFER_EN
      access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h1234_5678, 32'd0);
      check("hit_cycle", 32'(last_cyc), 32'd0);
      check("hit_addr_held", {14'd0, addr_log[0]}, 32'd5);
      access(1'b0, 1'b1, 32'd2000, 32'h55AA_55AA, 32'h1234_5678, 32'd11);
      access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h1234_5678, 32'd11);
      check("miss_after_wr_addr", {14'd0, addr_log[1]}, 32'd4);
`endif

      rd_en = 1'b0; wr_en = 1'b0; model_oe = 1'b0;
      repeat (3) @(posedge clk);
      check("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
